fetch_queue: RTL

- Parametrised instruction-fetch front end for the pipelined RV32 core.
- Replaces the bare PC register and single IF/ID latch with a PC generator feeding a DEPTH-entry prefetch FIFO of {pc, instr} pairs.
- Decouples instruction-memory wait states from decode stalls.
- Sits between the instruction memory port and the decode stage; a branch/jump redirect from EX/MEM flushes it.

---
 rtl/fetch_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator plus DEPTH-entry {pc, instr} prefetch FIFO (optional FETCH_BYPASS_EN)
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [XLEN-1:0]            iaddr,
    input  logic [XLEN-1:0]            idata,
    input  logic                       ivalid,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_instr,
    output logic [XLEN-1:0]            deq_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   occ;

    logic full;
    logic has_data;
    logic bypass;
    logic bypass_take;
    logic deq_fire;
    logic fetch_ok;
    logic enq_fire;
    logic wr_en;
    logic rd_en;

    assign iaddr    = fpc;
    assign count    = occ;
    assign full     = (occ == CW'(DEPTH));
    assign has_data = (occ != '0);

`ifdef FETCH_BYPASS_EN
    // Empty queue with a valid fetch: hand the word straight to decode.
    assign bypass    = ~has_data & ivalid & ~redirect_valid;
    assign deq_instr = bypass ? idata : instr_mem[rd_ptr];
    assign deq_pc    = bypass ? fpc   : pc_mem[rd_ptr];
`else
    assign bypass    = 1'b0;
    assign deq_instr = instr_mem[rd_ptr];
    assign deq_pc    = pc_mem[rd_ptr];
`endif

    assign deq_valid   = (has_data & ~redirect_valid) | bypass;
    assign deq_fire    = deq_valid & deq_ready;
    assign fetch_ok    = ~full | deq_fire;
    assign enq_fire    = fetch_ok & ivalid & ~redirect_valid;
    assign bypass_take = bypass & deq_ready;
    assign wr_en       = enq_fire & ~bypass_take;
    assign rd_en       = deq_fire & ~bypass_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Restart target is word aligned; low address bits are dropped.
            fpc    <= redirect_pc & ~XLEN'(3);
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                pc_mem[wr_ptr]    <= fpc;
                instr_mem[wr_ptr] <= idata;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (enq_fire) begin
                fpc <= fpc + XLEN'(PC_STEP);
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule
